video_hsmooth121: RTL and testbench
===================================

# video_hsmooth121

Horizontal [1 2 1]/4 smoothing pre-filter sitting directly upstream of the colour-detection image processor in the camera video pipeline. Takes the 24-bit RGB Avalon-ST packet stream from the camera path, low-pass filters each video row per channel to suppress single-pixel noise before MSB-threshold colour classification, and forwards non-video packets and header beats untouched. Output stream format and packet boundaries are identical to the input.

## Interface
- IMAGE_W, 640, pixels per row; x counter wrap point.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- sink_data  in  24  {R,G,B} beat.
- sink_valid / sink_sop / sink_eop  in  1  Avalon-ST sink qualifiers.
- sink_ready  out  1  sink backpressure.
- source_data  out  24  filtered beat.
- source_valid / source_sop / source_eop  out  1  source qualifiers.
- source_ready  in  1  downstream backpressure.
- enable  in  1  conduit; 1 = filter video packets, 0 = bypass; sampled on sop beat only.
- drop_pulse  out  1  one-cycle pulse when a held pixel is discarded (sop received mid-packet).

## Operation
- Accept = sink_valid & sink_ready. Emit = load of output register.
- sop beat: forwarded unmodified with sop=1. Latch video = (sink_data[3:0]==0) & enable. Reset x=0. Next state: video ? IDLE : PASS.
- PASS: every beat forwarded unmodified, 1-beat register; eop beat returns to IDLE.
- IDLE (no held pixel, row start): accept pixel p; prev<=p (left replicate), cur<=p. If x==IMAGE_W-1 or eop: emit p unchanged (both neighbours replicated) with its eop, stay IDLE. Else -> HOLD.
- HOLD: accept pixel n; emit f(prev,cur,n); prev<=cur, cur<=n. If n is row end (x==IMAGE_W-1) or eop -> FLUSH, else stay HOLD.
- FLUSH: sink_ready=0; emit f(prev,cur,cur) (right replicate) carrying cur's eop; -> IDLE.
- f per channel: (a + 2b + c + 2) >> 2, 10-bit intermediate; result fits 8 bits (max 255), no saturation.
- x increments per accepted video pixel, wraps IMAGE_W-1 -> 0; reset on sop.
- sop arriving in HOLD/FLUSH: held pixel dropped, drop_pulse=1, new header forwarded, state per new packet. sop in FLUSH is not accepted (ready low) until flush emitted, then no drop.
- Reset mid-packet: state IDLE, held pixel discarded, output register cleared; stream resumes on next sop.

## Timing
- Reset values: source_valid=0, source_sop=0, source_eop=0, source_data=0, drop_pulse=0, state IDLE, x=0.
- Output register loads when (!source_valid | source_ready); sink_ready = (state!=FLUSH) & (!source_valid | source_ready), combinational from source_ready.
- source_* stable while source_valid & !source_ready.
- Latency: header/PASS beats 1 cycle; video pixel k (not row end) emitted the cycle pixel k+1 is accepted, plus 1 register stage; row-end/eop pixel emitted 1 cycle after FLUSH entry. One bubble on sink per row.
- Throughput: IMAGE_W accepted pixels per IMAGE_W+1 cycles under no backpressure.

## Structure
- Shared package: IMAGE_W default, packet-type code (4'h0 = video), state enum {IDLE, HOLD, FLUSH, PASS}.
- Sub-module smooth121_ch (8-bit a,b,c -> 8-bit out, combinational), instantiated 3x for R,G,B.
- Top holds FSM, prev/cur registers, x counter, output register.

## Test plan
- Header 24'h000000 sop, enable=1, row 10,20,30 (all channels, IMAGE_W=3, eop on last) -> out header, then 13, 20, 28 with eop on 28.
- Constant 8'hFF row, IMAGE_W=640 -> all outputs 8'hFF, no overflow; 640 outputs, one FLUSH bubble.
- Non-video header 24'h00000F followed by 5 beats -> all 5 beats bit-identical, 1-cycle latency, eop preserved.
- enable=0 at sop, video row 0,255,0 -> output 0,255,0 unchanged; enable toggled mid-packet ignored.
- source_ready held low 10 cycles mid-row -> source_data stable, sink_ready low, no pixel lost or duplicated (compare to golden model).
- sop injected after 2 pixels with no eop -> drop_pulse=1 exactly once, one pixel emitted before header, new packet filtered correctly.

Source files
------------

// File: rtl/video_hsmooth121_pkg.sv
// Shared definitions for the horizontal [1 2 1]/4 video smoothing pre-filter.
package video_hsmooth121_pkg;

  localparam int IMAGE_W_DEF = 640;

  // Low nibble of a header beat carries the packet type; 0 marks video.
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2,
    PASS  = 2'd3
  } state_t;

endpackage

// File: rtl/video_hsmooth121_smooth121_ch.sv
// One colour channel of the [1 2 1]/4 kernel with round-half-up; purely combinational.
module smooth121_ch (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] y
);

  logic [9:0] sum;

  // Worst case 4*255+2 = 1022 still fits 10 bits, so the shifted result never exceeds 255.
  assign sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
  assign y   = 8'(sum >> 2);

endmodule

// File: rtl/video_hsmooth121.sv
// Horizontal [1 2 1]/4 smoothing of 24-bit RGB Avalon-ST video rows; non-video packets pass untouched.
//
// state | meaning
// IDLE  | row start, no pixel held; next accepted pixel seeds prev/cur
// HOLD  | one pixel held in cur, waiting for its right neighbour
// FLUSH | row end reached; emit last pixel with right replicate, sink stalled
// PASS  | non-video or bypassed packet, beats forwarded as-is
module video_hsmooth121
  import video_hsmooth121_pkg::*;
#(
  parameter int IMAGE_W = IMAGE_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic        enable,
  output logic        drop_pulse
);

  localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);

  state_t        state, state_nxt;
  logic [XW-1:0] x;
  logic [23:0]   prev, cur;
  logic          cur_eop;

  logic          load, accept, row_end;
  logic [23:0]   nbr, filt;
  logic          emit, emit_sop, emit_eop;
  logic [23:0]   emit_data;
  logic          px_first, px_shift, x_clr, x_inc, drop;

  assign load       = !source_valid | source_ready;
  assign sink_ready = (state != FLUSH) & load;
  assign accept     = sink_valid & sink_ready;
  assign row_end    = (x == X_LAST) | sink_eop;

  // In FLUSH the right neighbour is the held pixel itself.
  assign nbr = (state == FLUSH) ? cur : sink_data;

  smooth121_ch u_ch_r (.a(prev[23:16]), .b(cur[23:16]), .c(nbr[23:16]), .y(filt[23:16]));
  smooth121_ch u_ch_g (.a(prev[15:8]),  .b(cur[15:8]),  .c(nbr[15:8]),  .y(filt[15:8]));
  smooth121_ch u_ch_b (.a(prev[7:0]),   .b(cur[7:0]),   .c(nbr[7:0]),   .y(filt[7:0]));

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_data = sink_data;
    emit_sop  = 1'b0;
    emit_eop  = sink_eop;
    px_first  = 1'b0;
    px_shift  = 1'b0;
    x_clr     = 1'b0;
    x_inc     = 1'b0;
    drop      = 1'b0;

    if (accept && sink_sop) begin
      // A header always wins: any pixel still held from the old packet is abandoned.
      emit     = 1'b1;
      emit_sop = 1'b1;
      x_clr    = 1'b1;
      drop     = (state == HOLD);
      if (sink_eop || ((sink_data[3:0] == PKT_VIDEO) && enable))
        state_nxt = IDLE;
      else
        state_nxt = PASS;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            px_first = 1'b1;
            x_inc    = 1'b1;
            if (row_end) emit = 1'b1;
            else         state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            emit      = 1'b1;
            emit_data = filt;
            emit_eop  = 1'b0;
            px_shift  = 1'b1;
            x_inc     = 1'b1;
            if (row_end) state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if (load) begin
            emit      = 1'b1;
            emit_data = filt;
            emit_eop  = cur_eop;
            state_nxt = IDLE;
          end
        end
        PASS: begin
          if (accept) begin
            emit = 1'b1;
            if (sink_eop) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      x            <= '0;
      prev         <= '0;
      cur          <= '0;
      cur_eop      <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop;

      if (x_clr)      x <= '0;
      else if (x_inc) x <= (x == X_LAST) ? '0 : x + 1'b1;

      if (px_first) begin
        prev    <= sink_data;
        cur     <= sink_data;
        cur_eop <= sink_eop;
      end else if (px_shift) begin
        prev    <= cur;
        cur     <= sink_data;
        cur_eop <= sink_eop;
      end

      if (load) begin
        source_valid <= emit;
        if (emit) begin
          source_data <= emit_data;
          source_sop  <= emit_sop;
          source_eop  <= emit_eop;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_hsmooth121.sv
// Directed self-checking bench for video_hsmooth121: filtering, bypass, backpressure, drop and reset.
module tb_video_hsmooth121;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready;
  logic        enable;
  logic        drop_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int stall_cnt = 0;

  logic [25:0] oq[$];
  int          oq_cyc[$];
  int          acc_cyc[$];
  logic [23:0] px[$];

  always #5 clk = ~clk;

  video_hsmooth121 dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .enable(enable), .drop_pulse(drop_pulse)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output beats are captured at the negedge preceding the edge that transfers them.
  always @(negedge clk) begin
    if (reset_n && source_valid && source_ready) begin
      oq.push_back({source_sop, source_eop, source_data});
      oq_cyc.push_back(cyc);
    end
    if (drop_pulse) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f121(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int s;
    s = int'(a) + 2 * int'(b) + int'(c) + 2;
    return 8'(s / 4);
  endfunction

  function automatic logic [23:0] filt(input logic [23:0] l, input logic [23:0] m, input logic [23:0] r);
    return {f121(l[23:16], m[23:16], r[23:16]), f121(l[15:8], m[15:8], r[15:8]), f121(l[7:0], m[7:0], r[7:0])};
  endfunction

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    bit ok;
    int n;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      ok = sink_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stall_cnt++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: observed=stalled expected=accepted data=%0h", d);
        break;
      end
    end
    if (ok) acc_cyc.push_back(cyc);
  endtask

  task automatic idle();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    oq.delete(); oq_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic expect_beat(input string tag, input logic [23:0] d, input logic s, input logic e);
    logic [25:0] b;
    if (oq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=none expected=%0h", tag, {s, e, d});
    end else begin
      b = oq.pop_front();
      chk(tag, 32'(b), 32'({s, e, d}));
    end
  endtask

  task automatic send_row(input bit eop_last);
    for (int i = 0; i < px.size(); i++) send(px[i], 1'b0, eop_last && (i == px.size() - 1));
  endtask

  // Golden model: per-channel kernel with left/right replicate at the row edges.
  task automatic expect_row(input string tag, input bit eop_last);
    int n;
    n = px.size();
    for (int i = 0; i < n; i++)
      expect_beat(tag, filt(px[(i == 0) ? 0 : i - 1], px[i], px[(i == n - 1) ? i : i + 1]),
                  1'b0, eop_last && (i == n - 1));
  endtask

  initial begin
    logic [23:0] b3[5];
    logic [23:0] hold_d;
    int d0;
    b3[0] = 24'h123456; b3[1] = 24'hABCDEF; b3[2] = 24'h0F0F0F; b3[3] = 24'h000001; b3[4] = 24'hFFFFF0;

    reset_n = 1'b0; enable = 1'b1; source_ready = 1'b1;
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(source_valid), 32'd0);
    chk("rst_sop", 32'(source_sop), 32'd0);
    chk("rst_eop", 32'(source_eop), 32'd0);
    chk("rst_data", 32'(source_data), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    chk("rst_sink_ready", 32'(sink_ready), 32'd1);
    reset_n = 1'b1;
    drain(2);

    // Short video row ended by eop: 10,20,30 -> 13,20,28
    clear();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0A0A, 1'b0, 1'b0);
    send(24'h141414, 1'b0, 1'b0);
    send(24'h1E1E1E, 1'b0, 1'b1);
    idle();
    drain(5);
    chk("t1_lat_hdr", 32'(oq_cyc[0]), 32'(acc_cyc[0]));
    chk("t1_lat_px0", 32'(oq_cyc[1]), 32'(acc_cyc[2]));
    chk("t1_lat_eop", 32'(oq_cyc[3]), 32'(acc_cyc[3] + 1));
    expect_beat("t1_hdr", 24'h000000, 1'b1, 1'b0);
    expect_beat("t1_px0", 24'h0D0D0D, 1'b0, 1'b0);
    expect_beat("t1_px1", 24'h141414, 1'b0, 1'b0);
    expect_beat("t1_px2", 24'h1C1C1C, 1'b0, 1'b1);
    chk("t1_count", 32'(oq.size()), 32'd0);

    // Full 640-pixel FF row (row end without eop), second short row, then a non-video packet back to back
    clear();
    stall_cnt = 0;
    send(24'h000000, 1'b1, 1'b0);
    px.delete();
    for (int i = 0; i < 640; i++) px.push_back(24'hFFFFFF);
    send_row(1'b0);
    px.delete();
    px.push_back(24'h0A0A0A); px.push_back(24'h141414); px.push_back(24'h1E1E1E);
    send_row(1'b1);
    send(24'h00000F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(b3[i], 1'b0, i == 4);
    idle();
    drain(5);
    chk("t2_bubbles", 32'(stall_cnt), 32'd2);
    for (int k = 644; k < 650; k++) chk("t3_latency", 32'(oq_cyc[k]), 32'(acc_cyc[k]));
    expect_beat("t2_hdr", 24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 640; i++) expect_beat("t2_ff", 24'hFFFFFF, 1'b0, 1'b0);
    expect_beat("t2_r2_px0", 24'h0D0D0D, 1'b0, 1'b0);
    expect_beat("t2_r2_px1", 24'h141414, 1'b0, 1'b0);
    expect_beat("t2_r2_px2", 24'h1C1C1C, 1'b0, 1'b1);
    expect_beat("t3_hdr", 24'h00000F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) expect_beat("t3_beat", b3[i], 1'b0, i == 4);
    chk("t23_count", 32'(oq.size()), 32'd0);

    // Bypass via enable=0 at sop; toggling enable mid-packet is ignored
    clear();
    enable = 1'b0;
    send(24'h000000, 1'b1, 1'b0);
    enable = 1'b1;
    send(24'h000000, 1'b0, 1'b0);
    enable = 1'b0;
    send(24'hFFFFFF, 1'b0, 1'b0);
    enable = 1'b1;
    send(24'h000000, 1'b0, 1'b1);
    idle();
    drain(5);
    expect_beat("t4_hdr", 24'h000000, 1'b1, 1'b0);
    expect_beat("t4_px0", 24'h000000, 1'b0, 1'b0);
    expect_beat("t4_px1", 24'hFFFFFF, 1'b0, 1'b0);
    expect_beat("t4_px2", 24'h000000, 1'b0, 1'b1);
    chk("t4_count", 32'(oq.size()), 32'd0);

    // Downstream stall of 10 cycles mid-row
    clear();
    px.delete();
    for (int i = 0; i < 6; i++) px.push_back({8'(i * 40 + 5), 8'(200 - i * 30), 8'(i * i * 7)});
    fork
      begin
        send(24'h000000, 1'b1, 1'b0);
        send_row(1'b1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        source_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 0) hold_d = source_data;
          chk("t5_valid_held", 32'(source_valid), 32'd1);
          chk("t5_data_stable", 32'(source_data), 32'(hold_d));
          chk("t5_sink_ready", 32'(sink_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        source_ready = 1'b1;
      end
    join
    drain(5);
    expect_beat("t5_hdr", 24'h000000, 1'b1, 1'b0);
    expect_row("t5_px", 1'b1);
    chk("t5_count", 32'(oq.size()), 32'd0);

    // New sop after two pixels without eop drops the held pixel
    clear();
    d0 = drop_cnt;
    send(24'h000000, 1'b1, 1'b0);
    send(24'h101010, 1'b0, 1'b0);
    send(24'h202020, 1'b0, 1'b0);
    send(24'h000000, 1'b1, 1'b0);
    send(24'h404040, 1'b0, 1'b0);
    send(24'h808080, 1'b0, 1'b0);
    send(24'hC0C0C0, 1'b0, 1'b1);
    idle();
    drain(5);
    chk("t6_drop_once", 32'(drop_cnt - d0), 32'd1);
    expect_beat("t6_hdr1", 24'h000000, 1'b1, 1'b0);
    expect_beat("t6_px_a", 24'h141414, 1'b0, 1'b0);
    expect_beat("t6_hdr2", 24'h000000, 1'b1, 1'b0);
    expect_beat("t6_px0", 24'h505050, 1'b0, 1'b0);
    expect_beat("t6_px1", 24'h808080, 1'b0, 1'b0);
    expect_beat("t6_px2", 24'hB0B0B0, 1'b0, 1'b1);
    chk("t6_count", 32'(oq.size()), 32'd0);

    // Reset mid-packet clears the output register; next packet filters normally
    send(24'h000000, 1'b1, 1'b0);
    send(24'h555555, 1'b0, 1'b0);
    send(24'h666666, 1'b0, 1'b0);
    idle();
    reset_n = 1'b0;
    drain(1);
    chk("t7_rst_valid", 32'(source_valid), 32'd0);
    chk("t7_rst_drop", 32'(drop_pulse), 32'd0);
    reset_n = 1'b1;
    drain(1);
    clear();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0A0A, 1'b0, 1'b0);
    send(24'h141414, 1'b0, 1'b0);
    send(24'h1E1E1E, 1'b0, 1'b1);
    idle();
    drain(5);
    expect_beat("t7_hdr", 24'h000000, 1'b1, 1'b0);
    expect_beat("t7_px0", 24'h0D0D0D, 1'b0, 1'b0);
    expect_beat("t7_px1", 24'h141414, 1'b0, 1'b0);
    expect_beat("t7_px2", 24'h1C1C1C, 1'b0, 1'b1);
    chk("t7_count", 32'(oq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
